inv_sub_bytes: RTL and testbench
================================

INV_SUB_BYTES -- requirements
Module: inv_sub_bytes

Interface
REQ-001 SHALL have parameter LANES, default 1, meaning bytes inverse-substituted per cycle; legal values 1, 2, 4, 8, 16.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, state_in holds a block to process.
REQ-005 SHALL have port in_ready, output, 1, block can accept a new input.
REQ-006 SHALL have port state_in, input, 128, AES state; byte k = state_in[127-8k -: 8], k = 0..15.
REQ-007 SHALL have port out_valid, output, 1, state_out holds a finished result.
REQ-008 SHALL have port out_ready, input, 1, downstream accepts state_out.
REQ-009 SHALL have port state_out, output, 128, InvSubBytes(state_in); same byte ordering as state_in.
REQ-010 SHALL have port busy, output, 1, high in RUN state.

Function
REQ-011 SHALL implement the FIPS-197 inverse S-box (InvSbox) as an internal 256-entry combinational table, instantiated LANES times; InvSbox(Sbox(x)) = x for all 8-bit x.
REQ-012 SHALL have FSM states IDLE, RUN, DONE.
REQ-013 IDLE: in_ready = 1; out_valid = 0; busy = 0.
REQ-014 Accept = in_valid & in_ready at a rising edge; on accept SHALL capture state_in into a 128-bit working register, clear byte index to 0, go to RUN.
REQ-015 RUN: each cycle SHALL replace working bytes idx .. idx+LANES-1 with their InvSbox values and advance idx by LANES.
REQ-016 On the RUN cycle processing the final group (idx = 16-LANES), SHALL go to DONE; RUN lasts exactly 16/LANES cycles.
REQ-017 Latency: out_valid SHALL rise 16/LANES+1 edges after the accept edge (17 for LANES=1, 2 for LANES=16).
REQ-018 DONE: out_valid = 1, state_out = working register; state_out SHALL remain stable while out_valid = 1 and out_ready = 0.
REQ-019 out_valid & out_ready at an edge SHALL return FSM to IDLE; out_valid falls that edge.
REQ-020 in_ready SHALL be 0 in RUN and DONE; in_valid asserted there SHALL be ignored and state_in not sampled.
REQ-021 In DONE with out_ready = 1 and in_valid = 1 same cycle: only the output handshake completes; new input is accepted no earlier than the next cycle in IDLE (no same-cycle turnaround).
REQ-022 Byte index SHALL be 4 bits, never exceed 15, and SHALL wrap to 0 only via a new accept.
REQ-023 state_out outside DONE SHALL show the working register (don't-care to consumers; only qualified by out_valid).
REQ-024 Changes to state_in after accept SHALL not affect the result.

Reset
REQ-025 reset = 1 at an edge SHALL force IDLE, clear working register and index to 0, giving in_ready = 1, out_valid = 0, busy = 0, state_out = 0.
REQ-026 Reset SHALL take priority over all handshakes; reset during RUN or DONE SHALL discard the block in flight with no out_valid pulse.
REQ-027 in_valid asserted in the same cycle as reset SHALL not be accepted.

Verification
REQ-028 LANES=1, state_in = 0x637C777BF26B6FC53001672BFED7AB76, in_valid 1 cycle, out_ready = 1 -> out_valid rises 17 edges after accept, state_out = 0x000102030405060708090A0B0C0D0E0F, busy high 16 cycles.
REQ-029 state_in = all 0x00 -> state_out = all 0x52; state_in = all 0x16 -> all 0xFF; byte 0xED -> 0x53.
REQ-030 out_ready held 0 for 10 cycles in DONE -> out_valid and state_out stable all 10 cycles; in_valid pulses meanwhile not accepted (in_ready = 0); out_ready = 1 -> IDLE next edge.
REQ-031 reset asserted at RUN cycle 8 -> next cycle in_ready = 1, out_valid = 0, state_out = 0; following block processes correctly with full 17-cycle latency.
REQ-032 LANES=16 and LANES=4, vector of REQ-028 -> identical state_out, latency 2 and 5 respectively.
REQ-033 Exhaustive: 16 blocks covering bytes 0x00..0xFF, each byte compared against a reference forward Sbox round trip -> all 256 values match.

Source files
------------

// File: rtl/inv_sub_bytes.sv
// inv_sub_bytes: AES InvSubBytes over one 128-bit state, LANES bytes per cycle.
// Valid/ready contract: a transfer happens on a rising edge where valid and
// ready are both high; valid must not depend on ready, and while out_valid is
// high and out_ready is low, state_out is held unchanged.
// The FSM state is exposed on state_dbg (0 = IDLE, 1 = RUN, 2 = DONE).
module inv_sub_bytes #(
  parameter int LANES = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy,
  output logic [1:0]   state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Byte index step per RUN cycle and the index of the final lane group.
  localparam logic [3:0] IDX_STEP = 4'(LANES);
  localparam logic [3:0] LAST_IDX = 4'(16 - LANES);

  // FIPS-197 inverse S-box. Entry x lives at bits [8*(255-x) +: 8], so the
  // first literal below is InvSbox(0x00). One row per high nibble.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,  // 0x
    128'h7ce339829b2fff87348e4344c4dee9cb,  // 1x
    128'h547b9432a6c2233dee4c950b42fac34e,  // 2x
    128'h082ea16628d924b2765ba2496d8bd125,  // 3x
    128'h72f8f66486689816d4a45ccc5d65b692,  // 4x
    128'h6c704850fdedb9da5e154657a78d9d84,  // 5x
    128'h90d8ab008cbcd30af7e45805b8b34506,  // 6x
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,  // 7x
    128'h3a9111414f67dcea97f2cfcef0b4e673,  // 8x
    128'h96ac7422e7ad3585e2f937e81c75df6e,  // 9x
    128'h47f11a711d29c5896fb7620eaa18be1b,  // Ax
    128'hfc563e4bc6d279209adbc0fe78cd5af4,  // Bx
    128'h1fdda8338807c731b11210592780ec5f,  // Cx
    128'h60517fa919b54a0d2de57a9f93c99cef,  // Dx
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,  // Ex
    128'h172b047eba77d626e169146355210c7d   // Fx
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX[{~x, 3'b000} +: 8];
  endfunction

  state_t       state_q;
  state_t       state_d;
  logic [127:0] work_q;
  logic [127:0] work_sub;
  logic [3:0]   idx_q;
  logic         accept;
  logic         last_group;

  logic [3:0]   lane_idx [LANES];
  logic [7:0]   lane_in  [LANES];
  logic [7:0]   lane_out [LANES];

  assign accept     = in_valid && (state_q == IDLE);
  assign last_group = (idx_q == LAST_IDX);

  // Pick the LANES working bytes addressed by the current index. Byte k sits
  // at bits [8*(15-k) +: 8]; ~k on 4 bits is 15-k.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_idx[l] = idx_q + 4'(l);
      lane_in[l]  = work_q[{~lane_idx[l], 3'b000} +: 8];
    end
  end

  // One inverse S-box table per lane.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign lane_out[g] = inv_sbox(lane_in[g]);
  end

  // Working register with the current lane group substituted.
  always_comb begin
    work_sub = work_q;
    for (int l = 0; l < LANES; l++) begin
      work_sub[{~lane_idx[l], 3'b000} +: 8] = lane_out[l];
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; output handshake and input handshake never share a cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last_group) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs decoded from the current state only.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      RUN:     busy      = 1'b1;
      DONE:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // Datapath: capture on accept, substitute one lane group per RUN cycle.
  // The index holds on the final group so it never exceeds 15.
  always_ff @(posedge clk) begin
    if (reset) begin
      work_q <= '0;
      idx_q  <= '0;
    end else if (accept) begin
      work_q <= state_in;
      idx_q  <= '0;
    end else if (state_q == RUN) begin
      work_q <= work_sub;
      if (!last_group) begin
        idx_q <= idx_q + IDX_STEP;
      end
    end
  end

  assign state_out = work_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_inv_sub_bytes.sv
// Testbench for inv_sub_bytes: random and directed blocks on a LANES=1 instance
// checked through an expected-result queue, plus latency/result checks on
// LANES=4 and LANES=16 instances.
module tb_inv_sub_bytes;

  localparam logic [127:0] VEC_IN  = 128'h637c777bf26b6fc53001672bfed7ab76;
  localparam logic [127:0] VEC_OUT = 128'h000102030405060708090a0b0c0d0e0f;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- DUT signals ----------------
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] state_in, state_out;
  logic [1:0]   state_dbg;

  logic         in_valid4, in_ready4, out_valid4, busy4;
  logic [127:0] state_out4;
  logic [1:0]   state_dbg4;
  logic         in_valid16, in_ready16, out_valid16, busy16;
  logic [127:0] state_out16;
  logic [1:0]   state_dbg16;
  logic         out_ready_x;

  inv_sub_bytes #(.LANES(1)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .state_in(state_in), .out_valid(out_valid), .out_ready(out_ready),
    .state_out(state_out), .busy(busy), .state_dbg(state_dbg)
  );

  inv_sub_bytes #(.LANES(4)) u_dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
    .state_in(state_in), .out_valid(out_valid4), .out_ready(out_ready_x),
    .state_out(state_out4), .busy(busy4), .state_dbg(state_dbg4)
  );

  inv_sub_bytes #(.LANES(16)) u_dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid16), .in_ready(in_ready16),
    .state_in(state_in), .out_valid(out_valid16), .out_ready(out_ready_x),
    .state_out(state_out16), .busy(busy16), .state_dbg(state_dbg16)
  );

  // ---------------- reference model ----------------
  logic [7:0] sbox_ref [256];
  logic [7:0] inv_ref  [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] w;
    w = {b, b} << n;
    return w[15:8];
  endfunction

  // Forward S-box from the field inverse and affine map; InvSbox is its inverse permutation.
  task automatic build_tables();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      sbox_ref[x] = s;
    end
    for (int x = 0; x < 256; x++) inv_ref[sbox_ref[x]] = 8'(x);
  endtask

  function automatic logic [127:0] model(input logic [127:0] blk);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[127 - 8*k -: 8] = inv_ref[blk[127 - 8*k -: 8]];
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  logic [127:0] exp_q [$];
  int           acc_q [$];
  int           n_checks = 0;
  int           n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations at each output handshake, checks latency, busy span and hold stability.
  logic         prev_hold, prev_valid;
  logic [127:0] hold_data;
  int           busy_cnt;
  initial begin
    int acc;
    prev_hold = 1'b0; prev_valid = 1'b0; hold_data = '0; busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_hold = 1'b0; prev_valid = 1'b0; busy_cnt = 0;
      end else begin
        if (prev_hold) begin
          check("hold_valid", 128'(out_valid), 128'd1);
          check("hold_data", state_out, hold_data);
        end
        if (busy) busy_cnt++;
        if (out_valid && !prev_valid) begin
          if (acc_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL spurious_valid: got out_valid=1 expected no block in flight");
          end else begin
            acc = acc_q.pop_front();
            check("latency", 128'(cyc - acc + 1), 128'd17);
          end
          check("busy_cycles", 128'(busy_cnt), 128'd16);
          busy_cnt = 0;
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_output: got %h expected none", state_out);
          end else begin
            check("result", state_out, exp_q.pop_front());
          end
        end
        prev_hold  = out_valid && !out_ready;
        hold_data  = state_out;
        prev_valid = out_valid;
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic rdy_rand = 1'b0;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  function automatic logic [127:0] rand_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at posedge+#1. Waits for in_ready, presents blk for exactly one accept edge.
  task automatic send(input logic [127:0] blk, input logic [127:0] exp);
    int waited;
    waited = 0;
    while (!in_ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 200 cycles");
      return;
    end
    in_valid = 1'b1;
    state_in = blk;
    @(posedge clk); #1;
    exp_q.push_back(exp);
    acc_q.push_back(cyc);
    in_valid = 1'b0;
    state_in = rand_blk();
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while ((exp_q.size() != 0 || out_valid) && waited < 2000) begin
      @(posedge clk); #1;
      waited++;
    end
    check("drain_empty", 128'(exp_q.size()), 128'd0);
  endtask

  task automatic lane_run(input int lanes);
    int  n;
    logic got;
    check("lane_in_ready", 128'(lanes == 4 ? in_ready4 : in_ready16), 128'd1);
    state_in = VEC_IN;
    if (lanes == 4) in_valid4 = 1'b1; else in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0; in_valid16 = 1'b0;
    state_in = rand_blk();
    n = 1; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      n++;
      got = (lanes == 4) ? out_valid4 : out_valid16;
    end
    check("lane_latency", 128'(n), 128'(16 / lanes + 1));
    check("lane_result", (lanes == 4) ? state_out4 : state_out16, VEC_OUT);
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [127:0] blk;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; state_in = '0;
    in_valid4 = 1'b0; in_valid16 = 1'b0; out_ready_x = 1'b1;
    build_tables();

    // Reset with in_valid high: nothing may be accepted.
    repeat (2) begin @(posedge clk); #1; end
    in_valid = 1'b1; state_in = VEC_IN;
    @(posedge clk); #1;
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_state_out", state_out, 128'd0);
    reset = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    check("post_rst_busy", 128'(busy), 128'd0);

    // Directed vectors with known answers.
    out_ready = 1'b1;
    send(VEC_IN, VEC_OUT);
    send({16{8'h00}}, {16{8'h52}});
    send({16{8'h16}}, {16{8'hff}});
    send({8'hed, {15{8'h00}}}, {8'h53, {15{8'h52}}});
    drain();

    // Every byte value once, with random backpressure.
    rdy_rand = 1'b1;
    for (int b = 0; b < 16; b++) begin
      for (int k = 0; k < 16; k++) blk[127 - 8*k -: 8] = 8'(16*b + k);
      send(blk, model(blk));
    end
    for (int i = 0; i < 20; i++) begin
      blk = rand_blk();
      send(blk, model(blk));
    end
    drain();
    rdy_rand = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;

    // Hold in DONE for 10 cycles while in_valid pulses are ignored.
    send(VEC_IN, VEC_OUT);
    for (int i = 0; i < 40 && !out_valid; i++) begin @(posedge clk); #1; end
    for (int i = 0; i < 10; i++) begin
      check("done_in_ready", 128'(in_ready), 128'd0);
      in_valid = (i % 2 == 0);
      state_in = rand_blk();
      @(posedge clk); #1;
    end
    // Output handshake and input valid in the same cycle: only the output completes.
    out_ready = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    check("turn_out_valid", 128'(out_valid), 128'd0);
    check("turn_in_ready", 128'(in_ready), 128'd1);
    check("turn_busy", 128'(busy), 128'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Reset at RUN cycle 8 discards the block in flight.
    send(rand_blk(), 128'd0);
    repeat (7) begin @(posedge clk); #1; end
    check("mid_run_busy", 128'(busy), 128'd1);
    reset = 1'b1; in_valid = 1'b1; state_in = rand_blk();
    @(posedge clk); #1;
    exp_q.delete(); acc_q.delete();
    check("abort_in_ready", 128'(in_ready), 128'd1);
    check("abort_out_valid", 128'(out_valid), 128'd0);
    check("abort_state_out", state_out, 128'd0);
    reset = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    check("abort_idle", 128'(busy), 128'd0);
    send(VEC_IN, VEC_OUT);
    drain();

    // Wider datapaths on the same vector.
    lane_run(4);
    lane_run(16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
